// File: rtl/adc_osr_pkg.sv
// Shared state encoding and elaboration helpers for the oversampling accumulator.
package adc_osr_pkg;

    localparam int unsigned OSR_CTRL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int unsigned out_bits(input int unsigned matrix_bits,
                                             input int unsigned osr_max_log2);
        return matrix_bits + osr_max_log2;
    endfunction

    // Requested exponents above the supported maximum saturate to the maximum.
    function automatic logic [OSR_CTRL_W-1:0] clamp_osr(input logic [OSR_CTRL_W-1:0] osr,
                                                        input int unsigned osr_max_log2);
        if (32'(osr) > osr_max_log2) begin
            return OSR_CTRL_W'(osr_max_log2);
        end
        return osr;
    endfunction

endpackage

// File: rtl/adc_osr_fifo.sv
// Small synchronous FIFO holding completed output words; head entry drives the read port.
module adc_osr_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adc_osr_accumulator.sv
// Sums 2^osr SAR results per output word and streams left-aligned words on valid/ready.
// Define ADC_OSR_FIFO_EN to buffer words in a FIFO_DEPTH-entry FIFO instead of one register.
module adc_osr_accumulator
    import adc_osr_pkg::*;
#(
    parameter  int unsigned MATRIX_BITS  = 12,
    parameter  int unsigned OSR_MAX_LOG2 = 4,
    parameter  int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned OUT_BITS     = out_bits(MATRIX_BITS, OSR_MAX_LOG2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_in,
    input  logic [OSR_CTRL_W-1:0]  osr_control_in,
    input  logic [MATRIX_BITS-1:0] result_in,
    input  logic                   conv_finished_strobe_in,
    output logic [OUT_BITS-1:0]    data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   overrun_out,
    input  logic                   clear_overrun_in,
    output logic                   busy_out
);

    localparam int unsigned CNT_W = (OSR_MAX_LOG2 > 0) ? OSR_MAX_LOG2 : 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OUT_BITS-1:0]   r_sum;
    logic [OUT_BITS-1:0]   w_sum_nxt;
    logic [OUT_BITS-1:0]   w_sum_acc;
    logic [OUT_BITS-1:0]   w_word;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_cnt_max;
    logic [OSR_CTRL_W-1:0] r_osr;
    logic [OSR_CTRL_W-1:0] w_osr_nxt;
    logic                  w_done;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic                  r_overrun;

    assign w_sum_acc = r_sum + OUT_BITS'(result_in);
    assign w_cnt_max = CNT_W'((32'd1 << r_osr) - 32'd1);
    // Left-align so every OSR setting yields the same full-scale word.
    assign w_word    = w_sum_acc << (OSR_CTRL_W'(OSR_MAX_LOG2) - r_osr);

    // Next-state, accumulator and word-completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_cnt_nxt   = r_cnt;
        w_osr_nxt   = r_osr;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_in) begin
                    w_state_nxt = ACCUM;
                    w_osr_nxt   = clamp_osr(osr_control_in, OSR_MAX_LOG2);
                end
            end
            ACCUM: begin
                if (!enable_in) begin
                    w_state_nxt = IDLE;
                    w_sum_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (conv_finished_strobe_in) begin
                    if (r_cnt == w_cnt_max) begin
                        w_done    = 1'b1;
                        w_sum_nxt = '0;
                        w_cnt_nxt = '0;
                        w_osr_nxt = clamp_osr(osr_control_in, OSR_MAX_LOG2);
                    end else begin
                        w_sum_nxt = w_sum_acc;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_osr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_osr   <= w_osr_nxt;
        end
    end

`ifdef ADC_OSR_FIFO_EN
    logic w_fifo_full;
    logic w_fifo_empty;

    assign valid_out = ~w_fifo_empty;
    assign w_pop     = valid_out & ready_in;
    assign w_full    = w_fifo_full & ~w_pop;

    adc_osr_fifo #(
        .WIDTH (OUT_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_data  (data_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );
`else
    logic [OUT_BITS-1:0] r_data;
    logic                r_valid;

    assign w_pop     = r_valid & ready_in;
    assign w_full    = r_valid & ~ready_in;
    assign data_out  = r_data;
    assign valid_out = r_valid;

    // Single output register; data is held until the reader takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    // Depth only matters for the FIFO build.
    if (FIFO_DEPTH == 0) begin : g_fifo_depth_unused
    end
`endif

    assign w_push = w_done & ~w_full;
    assign w_drop = w_done & w_full;

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun_in) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun_out = r_overrun;
    assign busy_out    = (r_state == ACCUM);

endmodule

// File: tb/tb_adc_osr_accumulator.sv
// Self-checking bench for adc_osr_accumulator: directed scenarios plus a randomized run against a queue model.
`timescale 1ns/1ps
module tb_adc_osr_accumulator;

    localparam int OL = 4;
`ifdef ADC_OSR_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable_in;
    logic [3:0]  osr_control_in;
    logic [11:0] result_in;
    logic        conv_finished_strobe_in;
    logic [15:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic        overrun_out;
    logic        clear_overrun_in;
    logic        busy_out;

    int checks;
    int failures;

    // Reference model state: per-word sample sum, stored words, sticky flag.
    bit m_acc;
    int m_osr;
    int m_sum;
    int m_cnt;
    int mq[$];
    bit m_ovr;

    adc_osr_accumulator dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .enable_in               (enable_in),
        .osr_control_in          (osr_control_in),
        .result_in               (result_in),
        .conv_finished_strobe_in (conv_finished_strobe_in),
        .data_out                (data_out),
        .valid_out               (valid_out),
        .ready_in                (ready_in),
        .overrun_out             (overrun_out),
        .clear_overrun_in        (clear_overrun_in),
        .busy_out                (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        return (v > OL) ? OL : v;
    endfunction

    task automatic model_reset();
        m_acc = 1'b0;
        m_osr = 0;
        m_sum = 0;
        m_cnt = 0;
        mq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic model_step(input bit en, input int ctl, input int res, input bit stb,
                              input bit rdy, input bit clr);
        bit pop;
        bit done;
        bit set;
        int word;
        pop  = (mq.size() > 0) && rdy;
        done = 1'b0;
        set  = 1'b0;
        word = 0;
        if (!m_acc) begin
            if (en) begin
                m_acc = 1'b1;
                m_osr = clamp(ctl);
            end
        end else if (!en) begin
            m_acc = 1'b0;
            m_sum = 0;
            m_cnt = 0;
        end else if (stb) begin
            m_sum += res;
            m_cnt++;
            if (m_cnt == (1 << m_osr)) begin
                word  = m_sum * (1 << (OL - m_osr));
                done  = 1'b1;
                m_sum = 0;
                m_cnt = 0;
                m_osr = clamp(ctl);
            end
        end
        if (pop) void'(mq.pop_front());
        if (done) begin
            if (mq.size() < DEPTH) mq.push_back(word);
            else set = 1'b1;
        end
        if (set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    // One clock: drive inputs while clk is low, advance the model at the edge, return at negedge.
    task automatic cycle(input bit en, input int ctl, input int res, input bit stb,
                         input bit rdy, input bit clr);
        enable_in               = en;
        osr_control_in          = 4'(ctl);
        result_in               = 12'(res);
        conv_finished_strobe_in = stb;
        ready_in                = rdy;
        clear_overrun_in        = clr;
        @(posedge clk);
        model_step(en, ctl, res, stb, rdy, clr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_in = 1'b0; osr_control_in = '0; result_in = '0;
        conv_finished_strobe_in = 1'b0; ready_in = 1'b0; clear_overrun_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_out); end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++;
        if (overrun_out !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun_out); end
        checks++;
        if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
        rst_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_passthrough();
        cycle(1, 0, 0, 0, 0, 0);
        checks++;
        if (busy_out !== 1'b1) begin failures++; $display("FAIL pass_busy got=%b exp=1", busy_out); end
        cycle(1, 0, 'hABC, 1, 0, 0);
        checks++;
        if (valid_out !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b exp=1", valid_out); end
        checks++;
        if (data_out !== 16'hABC0) begin failures++; $display("FAIL pass_data got=%h exp=abc0", data_out); end
        cycle(1, 0, 0, 0, 1, 0);
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL pass_pop got=%b exp=0", valid_out); end
    endtask

    task automatic test_osr2();
        cycle(0, 2, 0, 0, 1, 0);
        cycle(1, 2, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2, 100 + i, 1, 1, 0);
            if (i < 3) begin
                checks++;
                if (valid_out !== 1'b0) begin failures++; $display("FAIL osr2_early_valid strobe=%0d got=%b exp=0", i, valid_out); end
                cycle(1, 2, 0, 0, 1, 0);
            end
        end
        checks++;
        if (valid_out !== 1'b1) begin failures++; $display("FAIL osr2_valid got=%b exp=1", valid_out); end
        checks++;
        if (data_out !== 16'd1624) begin failures++; $display("FAIL osr2_data got=%0d exp=1624", data_out); end
        cycle(1, 2, 0, 0, 1, 0);
    endtask

    task automatic test_osr4_clamp();
        cycle(0, 7, 0, 0, 1, 0);
        cycle(1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 7, 'hFFF, 1, 0, 0);
            if (i == 14) begin
                checks++;
                if (valid_out !== 1'b0) begin failures++; $display("FAIL clamp_early_valid got=%b exp=0", valid_out); end
            end
        end
        checks++;
        if (valid_out !== 1'b1) begin failures++; $display("FAIL clamp_valid got=%b exp=1", valid_out); end
        checks++;
        if (data_out !== 16'hFFF0) begin failures++; $display("FAIL clamp_data got=%h exp=fff0", data_out); end
        cycle(1, 7, 0, 0, 1, 0);
    endtask

    task automatic test_overrun();
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 0, k, 1, 0, 0);
            checks++;
            if (overrun_out !== (k > DEPTH)) begin
                failures++;
                $display("FAIL ovr_flag strobe=%0d got=%b exp=%b", k, overrun_out, (k > DEPTH));
            end
        end
        cycle(1, 0, 7, 1, 0, 1);
        checks++;
        if (overrun_out !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%b exp=1", overrun_out); end
        cycle(1, 0, 0, 0, 0, 1);
        checks++;
        if (overrun_out !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun_out); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (valid_out !== 1'b1 || data_out !== 16'((i + 1) << 4)) begin
                failures++;
                $display("FAIL ovr_held idx=%0d got=%b/%h exp=1/%h", i, valid_out, data_out, 16'((i + 1) << 4));
            end
            cycle(1, 0, 0, 0, 1, 0);
        end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL ovr_drained got=%b exp=0", valid_out); end
    endtask

    task automatic test_back_to_back();
        int exp[$];
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 20 + i, 1, 0, 0);
            exp.push_back((20 + i) << 4);
        end
        cycle(1, 0, 99, 1, 1, 0);
        void'(exp.pop_front());
        exp.push_back(99 << 4);
        checks++;
        if (overrun_out !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun_out); end
        while (exp.size() > 0) begin
            checks++;
            if (valid_out !== 1'b1 || data_out !== 16'(exp[0])) begin
                failures++;
                $display("FAIL b2b_word got=%b/%h exp=1/%h", valid_out, data_out, 16'(exp[0]));
            end
            cycle(1, 0, 0, 0, 1, 0);
            void'(exp.pop_front());
        end
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", valid_out); end
    endtask

    task automatic test_enable_drop();
        cycle(0, 3, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 3, int'($urandom_range(0, 4095)), 1, 0, 0);
        cycle(0, 3, 500, 1, 0, 0);
        checks++;
        if (busy_out !== 1'b0 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL endrop_idle busy/valid got=%b/%b exp=0/0", busy_out, valid_out);
        end
        cycle(1, 3, 0, 0, 0, 0);
        checks++;
        if (busy_out !== 1'b1) begin failures++; $display("FAIL endrop_busy got=%b exp=1", busy_out); end
        for (int i = 0; i < 8; i++) cycle(1, 3, 10, 1, 0, 0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 16'd160) begin
            failures++;
            $display("FAIL endrop_word got=%b/%0d exp=1/160", valid_out, data_out);
        end
        cycle(1, 3, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit en, stb, rdy, clr;
        int ctl, res;
        for (int n = 0; n < 3000; n++) begin
            en  = ($urandom_range(0, 99) != 0);
            ctl = int'($urandom_range(0, 7));
            res = int'($urandom_range(0, 4095));
            stb = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            cycle(en, ctl, res, stb, rdy, clr);
            checks++;
            if (valid_out !== (mq.size() > 0)) begin
                failures++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, valid_out, (mq.size() > 0));
            end
            if (mq.size() > 0) begin
                checks++;
                if (data_out !== 16'(mq[0])) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, data_out, 16'(mq[0]));
                end
            end
            checks++;
            if (overrun_out !== m_ovr) begin
                failures++;
                $display("FAIL rnd_overrun cyc=%0d got=%b exp=%b", n, overrun_out, m_ovr);
            end
            checks++;
            if (busy_out !== m_acc) begin
                failures++;
                $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", n, busy_out, m_acc);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 3, 5, 1, 0, 0);
        cycle(1, 3, 9, 1, 0, 0);
        cycle(1, 3, 9, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 16'h0000 || valid_out !== 1'b0 || overrun_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset data/valid/ovr/busy got=%h/%b/%b/%b exp=0000/0/0/0",
                     data_out, valid_out, overrun_out, busy_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 'h123, 1, 0, 0);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 16'h1230) begin
            failures++;
            $display("FAIL post_reset_word got=%b/%h exp=1/1230", valid_out, data_out);
        end
        cycle(1, 0, 0, 0, 1, 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_passthrough();
        test_osr2();
        test_osr4_clamp();
        test_overrun();
        test_back_to_back();
        test_enable_drop();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
